// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage behind the program counter. It captures the halfword-aligned PC
// and reads the 16-bit big-endian instruction at that address as two bytes over
// an 8-bit req/ack memory port. The result is held for the decoder behind a
// valid/ready handshake. A flush (jump taken) discards any in-flight or held
// instruction. A request that is still outstanding is drained so that the
// memory handshake is never violated.
//
// Ports
//   clk_in           rising-edge clock
//   reset_in         synchronous, active-high reset
//   fetch_en_in      permits a new fetch to start from IDLE
//   pc_in[15:0]      current PC; bit 0 is ignored
//   flush_in         jump taken; drop the current fetch or the held instruction
//   mem_req_out      memory read request (level, held until acked)
//   mem_addr_out     byte address of the request
//   mem_ack_in       memory accepted the request; mem_rdata_in valid this cycle
//   mem_rdata_in     read byte
//   instr_out        fetched instruction
//   instr_pc_out     address of instr_out (bit 0 = 0)
//   instr_valid_out  instr_out / instr_pc_out are valid
//   instr_ready_in   decoder accepts the instruction
// -----------------------------------------------------------------------------
module instruction_fetch (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        fetch_en_in,
    input  logic [15:0] pc_in,
    input  logic        flush_in,
    output logic        mem_req_out,
    output logic [15:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [7:0]  mem_rdata_in,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_HI,
        S_REQ_LO,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;

    logic        w_mem_req;
    logic [15:0] w_mem_addr;
    logic [15:0] w_instr;
    logic [15:0] w_instr_pc;
    logic        w_instr_valid;

    // State and output registers. All outputs come straight from flops, so
    // nothing combinational reaches a port.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 16'h0000;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_instr       <= w_instr;
            r_instr_pc    <= w_instr_pc;
            r_instr_valid <= w_instr_valid;
        end
    end

    // Next-state logic. A flush that arrives with no ack cannot simply drop the
    // request, so the fetch parks in DRAIN until the memory acknowledges it.
    // NOTE: the default assignment at the top of every always_comb keeps each
    // path assigned and prevents latch inference.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (fetch_en_in && !flush_in) begin
                    w_next_state = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (flush_in) begin
                    w_next_state = mem_ack_in ? S_IDLE : S_DRAIN;
                end else if (mem_ack_in) begin
                    w_next_state = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (flush_in) begin
                    w_next_state = mem_ack_in ? S_IDLE : S_DRAIN;
                end else if (mem_ack_in) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                // A flush coinciding with ready still counts as a transfer;
                // both cases end in IDLE.
                if (instr_ready_in || flush_in) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_ack_in) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the output registers. Request and valid
    // are decoded from the next state, so they line up with the state register.
    always_comb begin
        w_mem_addr    = r_mem_addr;
        w_instr       = r_instr;
        w_instr_pc    = r_instr_pc;
        w_mem_req     = (w_next_state == S_REQ_HI) ||
                        (w_next_state == S_REQ_LO) ||
                        (w_next_state == S_DRAIN);
        w_instr_valid = (w_next_state == S_HOLD);

        case (r_state)
            S_IDLE: begin
                if (w_next_state == S_REQ_HI) begin
                    w_instr_pc = {pc_in[15:1], 1'b0};
                    w_mem_addr = {pc_in[15:1], 1'b0};
                end
            end
            S_REQ_HI: begin
                // Bytes acked together with a flush are discarded.
                if (mem_ack_in && !flush_in) begin
                    w_instr[15:8] = mem_rdata_in;
                    // Bit 0 is set rather than added: 0xFFFE reads 0xFFFF, no carry.
                    w_mem_addr    = r_instr_pc | 16'h0001;
                end
            end
            S_REQ_LO: begin
                if (mem_ack_in && !flush_in) begin
                    w_instr[7:0] = mem_rdata_in;
                end
            end
            default: ;
        endcase
    end

    assign mem_req_out     = r_mem_req;
    assign mem_addr_out    = r_mem_addr;
    assign instr_out       = r_instr;
    assign instr_pc_out    = r_instr_pc;
    assign instr_valid_out = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Testbench for instruction_fetch. The directed steps follow the fetch
// scenarios: basic, odd PC wrap, wait states with backpressure, flushes, and
// reset mid-fetch. A randomized phase then compares every output, every cycle,
// against a transaction-level reference model. Inputs change 1 ns after the
// rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        fetch_en_in;
    logic [15:0] pc_in;
    logic        flush_in;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in;
    logic [7:0]  mem_rdata_in;
    logic [15:0] instr_out;
    logic [15:0] instr_pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .fetch_en_in     (fetch_en_in),
        .pc_in           (pc_in),
        .flush_in        (flush_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_rdata_in    (mem_rdata_in),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_valid_out (instr_valid_out),
        .instr_ready_in  (instr_ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Memory contents: the two bytes from the basic scenario, and a hash of
    // the address everywhere else.
    function automatic logic [7:0] mem_byte(input logic [15:0] addr);
        if (addr == 16'h0010) return 8'h12;
        if (addr == 16'h0011) return 8'h34;
        return addr[7:0] ^ addr[15:8] ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   {15'd0, mem_req_out},     16'd0);
        check({tag, "_valid"}, {15'd0, instr_valid_out}, 16'd0);
    endtask

    // One complete fetch: start from IDLE, give wait_cyc wait cycles per byte,
    // then hold ready low for ready_wait cycles before accepting.
    task automatic do_fetch(input string tag, input logic [15:0] pc,
                            input int wait_cyc, input int ready_wait);
        logic [15:0] base;
        logic [15:0] exp_instr;
        base      = {pc[15:1], 1'b0};
        exp_instr = {mem_byte(base), mem_byte(base | 16'h0001)};
        pc_in          = pc;
        fetch_en_in    = 1'b1;
        instr_ready_in = 1'b0;
        tick();
        fetch_en_in = 1'b0;
        check({tag, "_pc_latched"}, instr_pc_out, base);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < wait_cyc; w++) begin
                check({tag, "_wait_req"},   {15'd0, mem_req_out}, 16'd1);
                check({tag, "_wait_addr"},  mem_addr_out, base | 16'(b));
                check({tag, "_wait_valid"}, {15'd0, instr_valid_out}, 16'd0);
                mem_ack_in = 1'b0;
                tick();
            end
            check({tag, "_req"},  {15'd0, mem_req_out}, 16'd1);
            check({tag, "_addr"}, mem_addr_out, base | 16'(b));
            mem_ack_in   = 1'b1;
            mem_rdata_in = mem_byte(base | 16'(b));
            tick();
            mem_ack_in = 1'b0;
        end
        check({tag, "_valid"},    {15'd0, instr_valid_out}, 16'd1);
        check({tag, "_instr"},    instr_out, exp_instr);
        check({tag, "_instr_pc"}, instr_pc_out, base);
        check({tag, "_req_low"},  {15'd0, mem_req_out}, 16'd0);
        for (int r = 0; r < ready_wait; r++) begin
            tick();
            check({tag, "_bp_valid"}, {15'd0, instr_valid_out}, 16'd1);
            check({tag, "_bp_instr"}, instr_out, exp_instr);
            check({tag, "_bp_pc"},    instr_pc_out, base);
        end
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;
        check({tag, "_valid_drop"}, {15'd0, instr_valid_out}, 16'd0);
    endtask

    // Reference model state (transaction level: busy flag, byte count, drain).
    logic        m_busy, m_drain, m_valid;
    int          m_bytes;
    logic [15:0] m_base, m_addr, m_instr;

    task automatic model_reset();
        m_busy = 1'b0; m_drain = 1'b0; m_valid = 1'b0; m_bytes = 0;
        m_base = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        if (reset_in) begin
            model_reset();
        end else if (m_valid) begin
            if (instr_ready_in || flush_in) m_valid = 1'b0;
        end else if (!m_busy) begin
            if (fetch_en_in && !flush_in) begin
                m_busy  = 1'b1;
                m_bytes = 0;
                m_base  = {pc_in[15:1], 1'b0};
                m_addr  = m_base;
            end
        end else if (m_drain) begin
            if (mem_ack_in) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end
        end else if (flush_in) begin
            if (mem_ack_in) m_busy = 1'b0;
            else            m_drain = 1'b1;
        end else if (mem_ack_in) begin
            if (m_bytes == 0) begin
                m_instr[15:8] = mem_rdata_in;
                m_bytes       = 1;
                m_addr        = m_base + 16'd1;
            end else begin
                m_instr[7:0] = mem_rdata_in;
                m_busy       = 1'b0;
                m_valid      = 1'b1;
            end
        end
    endtask

    logic [15:0] last_instr;

    initial begin
        reset_in       = 1'b1;
        fetch_en_in    = 1'b0;
        pc_in          = 16'h0000;
        flush_in       = 1'b0;
        mem_ack_in     = 1'b0;
        mem_rdata_in   = 8'h00;
        instr_ready_in = 1'b0;

        // Reset values.
        tick();
        tick();
        reset_in = 1'b0;
        check("rst_req",      {15'd0, mem_req_out},     16'd0);
        check("rst_addr",     mem_addr_out,             16'h0000);
        check("rst_instr",    instr_out,                16'h0000);
        check("rst_instr_pc", instr_pc_out,             16'h0000);
        check("rst_valid",    {15'd0, instr_valid_out}, 16'd0);

        // Basic fetch with explicit N+3 latency.
        pc_in = 16'h0010; fetch_en_in = 1'b1; instr_ready_in = 1'b1;
        tick();                                 // edge N sampled fetch_en
        fetch_en_in = 1'b0;
        check("basic_n1_req",  {15'd0, mem_req_out}, 16'd1);
        check("basic_n1_addr", mem_addr_out, 16'h0010);
        mem_ack_in = 1'b1; mem_rdata_in = mem_byte(mem_addr_out);
        tick();
        check("basic_n2_req",  {15'd0, mem_req_out}, 16'd1);
        check("basic_n2_addr", mem_addr_out, 16'h0011);
        check("basic_n2_valid", {15'd0, instr_valid_out}, 16'd0);
        mem_rdata_in = mem_byte(mem_addr_out);
        tick();
        mem_ack_in = 1'b0;
        check("basic_n3_valid", {15'd0, instr_valid_out}, 16'd1);
        check("basic_n3_instr", instr_out, 16'h1234);
        check("basic_n3_pc",    instr_pc_out, 16'h0010);
        check("basic_n3_req",   {15'd0, mem_req_out}, 16'd0);
        tick();
        instr_ready_in = 1'b0;
        check("basic_n4_valid", {15'd0, instr_valid_out}, 16'd0);

        // Odd PC and address wrap.
        do_fetch("wrap", 16'hFFFF, 0, 0);

        // Wait states and backpressure.
        do_fetch("wait_bp", 16'h0100, 3, 5);

        // Flush in IDLE: no fetch starts.
        pc_in = 16'h0040; fetch_en_in = 1'b1; flush_in = 1'b1;
        tick();
        fetch_en_in = 1'b0; flush_in = 1'b0;
        check_idle_outputs("flush_idle");

        // Flush in REQ_LO, ack two cycles later via DRAIN.
        pc_in = 16'h0010; fetch_en_in = 1'b1;
        tick();
        fetch_en_in = 1'b0;
        mem_ack_in = 1'b1; mem_rdata_in = mem_byte(mem_addr_out);
        tick();
        mem_ack_in = 1'b0;
        check("fl_lo_addr", mem_addr_out, 16'h0011);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("fl_drain1_req",   {15'd0, mem_req_out}, 16'd1);
        check("fl_drain1_addr",  mem_addr_out, 16'h0011);
        check("fl_drain1_valid", {15'd0, instr_valid_out}, 16'd0);
        tick();
        check("fl_drain2_req",   {15'd0, mem_req_out}, 16'd1);
        check("fl_drain2_addr",  mem_addr_out, 16'h0011);
        check("fl_drain2_valid", {15'd0, instr_valid_out}, 16'd0);
        mem_ack_in = 1'b1; mem_rdata_in = 8'hEE;
        tick();
        mem_ack_in = 1'b0;
        check_idle_outputs("fl_drain_done");
        tick();
        check_idle_outputs("fl_drain_idle");

        // Flush in HOLD.
        pc_in = 16'h0200; fetch_en_in = 1'b1;
        tick();
        fetch_en_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_ack_in = 1'b1; mem_rdata_in = mem_byte(mem_addr_out);
            tick();
        end
        mem_ack_in = 1'b0;
        check("fl_hold_valid", {15'd0, instr_valid_out}, 16'd1);
        last_instr = {mem_byte(16'h0200), mem_byte(16'h0201)};
        check("fl_hold_instr", instr_out, last_instr);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_idle_outputs("fl_hold_after");

        // Flush coincident with the high-byte ack: byte discarded.
        pc_in = 16'h0300; fetch_en_in = 1'b1;
        tick();
        fetch_en_in = 1'b0;
        flush_in = 1'b1; mem_ack_in = 1'b1; mem_rdata_in = 8'hA5;
        tick();
        flush_in = 1'b0; mem_ack_in = 1'b0;
        check_idle_outputs("fl_ack_after");
        check("fl_ack_instr_kept", instr_out, last_instr);
        tick();
        check_idle_outputs("fl_ack_idle");

        // Reset asserted in REQ_HI.
        pc_in = 16'h0400; fetch_en_in = 1'b1;
        tick();
        fetch_en_in = 1'b0;
        check("rst_mid_req", {15'd0, mem_req_out}, 16'd1);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("rst_mid_req0",   {15'd0, mem_req_out},     16'd0);
        check("rst_mid_addr",   mem_addr_out,             16'h0000);
        check("rst_mid_instr",  instr_out,                16'h0000);
        check("rst_mid_pc",     instr_pc_out,             16'h0000);
        check("rst_mid_valid",  {15'd0, instr_valid_out}, 16'd0);
        do_fetch("post_rst", 16'h0020, 0, 0);

        // Randomized phase against the reference model.
        reset_in = 1'b1;
        model_step();
        tick();
        reset_in = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            reset_in       = ($urandom_range(0, 99) == 0);
            fetch_en_in    = $urandom_range(0, 1) != 0;
            pc_in          = 16'($urandom);
            flush_in       = ($urandom_range(0, 7) == 0);
            instr_ready_in = $urandom_range(0, 1) != 0;
            mem_ack_in     = $urandom_range(0, 2) == 0;
            mem_rdata_in   = 8'($urandom);
            model_step();
            tick();
            check("rnd_req",   {15'd0, mem_req_out},     {15'd0, m_busy});
            check("rnd_addr",  mem_addr_out,             m_addr);
            check("rnd_instr", instr_out,                m_instr);
            check("rnd_pc",    instr_pc_out,             m_base);
            check("rnd_valid", {15'd0, instr_valid_out}, {15'd0, m_valid});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of the program counter. It captures the halfword-aligned PC, reads the 16-bit instruction at that address as two big-endian bytes over the 8-bit req/ack memory port, and holds the result for the decoder behind a valid/ready handshake. It also supports jump flushes without violating the memory handshake.

## Interface
Parameters: none. Address width is 16 bits, instruction width is 16 bits, and the memory data width is 8 bits; all are fixed.

Ports:
- clk_in  input  1  clock; all logic samples on the rising edge.
- reset_in  input  1  reset, synchronous and active-high.
- fetch_en_in  input  1  permits starting a new fetch from IDLE.
- pc_in  input  16  current PC from program_counter_out; bit 0 is ignored.
- flush_in  input  1  jump taken; discards any in-progress or held instruction.
- mem_req_out  output  1  memory read request (level).
- mem_addr_out  output  16  byte address of the request.
- mem_ack_in  input  1  memory accepted the request; mem_rdata_in is valid in the same cycle.
- mem_rdata_in  input  8  read byte.
- instr_out  output  16  fetched instruction.
- instr_pc_out  output  16  address of instr_out, with bit 0 = 0.
- instr_valid_out  output  1  instr_out / instr_pc_out are valid.
- instr_ready_in  input  1  decoder accepts the instruction.

## Operation
- States: IDLE, REQ_HI, REQ_LO, HOLD, DRAIN.
- IDLE
  - All outputs are held, and instr_valid_out = 0.
  - If fetch_en_in=1 and flush_in=0: latch base = {pc_in[15:1],1'b0} into instr_pc_out, then go to REQ_HI.
- REQ_HI
  - mem_req_out=1, mem_addr_out=base.
  - On mem_ack_in: instr_out[15:8] <= mem_rdata_in, then go to REQ_LO.
- REQ_LO
  - mem_req_out=1, mem_addr_out=base|1. Bit 0 is set rather than added, so there is no carry: base 0xFFFE reads 0xFFFE then 0xFFFF.
  - On mem_ack_in: instr_out[7:0] <= mem_rdata_in, then go to HOLD.
- HOLD
  - instr_valid_out=1; instr_out and instr_pc_out are stable.
  - If instr_ready_in=1 the transfer occurs, then go to IDLE.
  - The next fetch starts no earlier than the cycle after the transfer, and uses pc_in as sampled in IDLE. The control path advances the PC on the transfer cycle.
- DRAIN
  - mem_req_out=1 with the address unchanged.
  - On mem_ack_in: discard the byte and go to IDLE.
- Memory handshake rules:
  - Once mem_req_out rises, it and mem_addr_out must stay unchanged until mem_ack_in is sampled high.
  - A request is never withdrawn without an ack.
- Flush handling (flush_in=1):
  - In IDLE: no fetch starts.
  - In HOLD: go to IDLE; instr_valid_out=0 next cycle. If instr_ready_in is also 1, the transfer still counts; the next state is IDLE either way.
  - In REQ_HI or REQ_LO with mem_ack_in=1: accept and discard the byte, go to IDLE.
  - In REQ_HI or REQ_LO with mem_ack_in=0: go to DRAIN.
  - In DRAIN: no effect.
- Reset mid-operation: reset_in overrides everything, including an outstanding request. The memory side must tolerate a request dropped by reset.

## Timing
- Reset values:
  - State = IDLE.
  - mem_req_out=0, mem_addr_out=0x0000.
  - instr_out=0x0000, instr_pc_out=0x0000, instr_valid_out=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Best-case latency (ack in the first request cycle of each byte):
  - fetch_en_in sampled in IDLE at cycle N.
  - REQ_HI at N+1, REQ_LO at N+2, instr_valid_out=1 at N+3.
- Throughput: one instruction per 4 cycles with zero-wait memory and instr_ready_in held at 1.
- Each memory wait cycle extends its byte phase by one cycle.
- mem_req_out stays high continuously from REQ_HI through REQ_LO. The address changes on the cycle after the high-byte ack.

## Test plan
- Basic fetch:
  - Stimulus: reset, then pc_in=0x0010, fetch_en_in=1, memory returns 0x12 at 0x0010 and 0x34 at 0x0011 with zero wait, instr_ready_in=1.
  - Required response: instr_valid_out at N+3, instr_out=0x1234, instr_pc_out=0x0010. Sequence mem_addr_out=0x0010 then 0x0011.
- Odd PC and wrap:
  - Stimulus: pc_in=0xFFFF.
  - Required response: reads at 0xFFFE then 0xFFFF, instr_pc_out=0xFFFE.
- Wait states and backpressure:
  - Stimulus: 3 wait cycles per byte, instr_ready_in=0 for 5 cycles.
  - Required response: mem_addr_out and mem_req_out stable while unacked. Instruction held stable with valid=1 until ready rises, then valid=0 the next cycle.
- Flush mid-byte:
  - Stimulus: flush_in in REQ_LO with the ack 2 cycles later.
  - Required response: DRAIN keeps req/addr at 0x0011 until the ack. instr_valid_out never rises. Then back to IDLE.
- Flush in HOLD and flush with ack:
  - Stimulus: flush in HOLD; separately, flush coincident with the high-byte ack.
  - Required response: valid drops next cycle; IDLE next cycle with mem_req_out=0.
- Reset mid-fetch:
  - Stimulus: reset_in asserted in REQ_HI.
  - Required response: next cycle all outputs at their reset values. A subsequent fetch at pc_in=0x0020 completes correctly.
